cfg_frame_loader: RTL and testbench

- Byte-serial host-side writer for the encrypt/decrypt system's 32-bit configuration register.
- Accepts a 4-byte configuration frame over a valid/ready byte interface and assembles it MSB first.
- Asserts hold_data to stall the plaintext stream, waits for the encrypt/decrypt pipeline to drain, then issues a single-cycle cfg_wen with the assembled word.
- Sits between the host interface and the wrapper's cfg_wen/cfg_data_in inputs (non-HP_MODE builds only).

---
 rtl/cfg_frame_pkg.sv | 66 ++++++
 rtl/cfg_idle_counter.sv | 46 ++++
 rtl/cfg_frame_loader.sv | 196 +++++++++++++++++++
 tb/tb_cfg_frame_loader.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_frame_pkg.sv
// ---------------------------------------------------------------------------
// cfg_frame_pkg
// Shared definitions for the configuration frame loader:
//   - state encoding for the loader FSM (IDLE, COLLECT, DRAIN, COMMIT)
//   - CFG_FRAME_BYTES: bytes per frame (4, or 5 when CFG_CHECKSUM_EN adds a
//     trailing XOR checksum byte)
//   - bit positions of every field inside the 32-bit configuration word
//   - helpers to place a received byte into its lane and to compute the
//     frame checksum
// Optional build macro: CFG_CHECKSUM_EN
// ---------------------------------------------------------------------------
package cfg_frame_pkg;

    typedef logic [1:0] cfg_state_t;

    localparam cfg_state_t ST_IDLE    = 2'd0;
    localparam cfg_state_t ST_COLLECT = 2'd1;
    localparam cfg_state_t ST_DRAIN   = 2'd2;
    localparam cfg_state_t ST_COMMIT  = 2'd3;

`ifdef CFG_CHECKSUM_EN
    localparam int CFG_FRAME_BYTES = 5;
`else
    localparam int CFG_FRAME_BYTES = 4;
`endif

    localparam int K1_MSB       = 31;
    localparam int K1_LSB       = 24;
    localparam int K2_MSB       = 23;
    localparam int K2_LSB       = 16;
    localparam int K3_MSB       = 15;
    localparam int K3_LSB       = 8;
    localparam int SHIFT_EN_BIT = 7;
    localparam int ROT_MSB      = 6;
    localparam int ROT_LSB      = 4;
    localparam int SHAMT_MSB    = 3;
    localparam int SHAMT_LSB    = 1;
    localparam int MODE_BIT     = 0;

    // Frames arrive MSB first; lane 3 carries the packed control fields.
    // Lanes beyond 3 (the checksum byte) leave the word untouched.
    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [2:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (lane)
            3'd0: w[K1_MSB:K1_LSB] = b;
            3'd1: w[K2_MSB:K2_LSB] = b;
            3'd2: w[K3_MSB:K3_LSB] = b;
            3'd3: begin
                w[SHIFT_EN_BIT]        = b[7];
                w[ROT_MSB:ROT_LSB]     = b[6:4];
                w[SHAMT_MSB:SHAMT_LSB] = b[3:1];
                w[MODE_BIT]            = b[0];
            end
            default: ;
        endcase
        return w;
    endfunction

    function automatic logic [7:0] frame_xor(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

endpackage

// File: rtl/cfg_idle_counter.sv
// ---------------------------------------------------------------------------
// cfg_idle_counter
// 8-bit idle-cycle counter with clear, increment and terminal compare.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   inc       - advance the count this cycle
//   clr       - return the count to zero (wins over inc)
//   term      - terminal value to compare against
//   count     - current count
//   at_term   - count equals term
// ---------------------------------------------------------------------------
module cfg_idle_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [7:0] term,
    output logic [7:0] count,
    output logic       at_term
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Saturate rather than wrap so a long idle stretch never looks fresh.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (inc && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign at_term = (count_q == term);

endmodule

// File: rtl/cfg_frame_loader.sv
// ---------------------------------------------------------------------------
// cfg_frame_loader
// Byte-serial writer for the 32-bit configuration register. Collects a frame
// MSB first, stalls the plaintext stream with hold_data, waits until the
// datapath has been idle for DRAIN_CYCLES consecutive cycles, then issues a
// single-cycle cfg_wen with the assembled word.
// Parameters:
//   DRAIN_CYCLES   - idle cycles required before commit (1..255)
//   TIMEOUT_CYCLES - idle cycles allowed between bytes of a frame (1..255)
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   byte_valid    - host byte valid
//   byte_data     - host byte
//   byte_ready    - loader accepts a byte this cycle
//   data_active   - datapath enable currently asserted
//   hold_data     - upstream must stall the datapath
//   cfg_wen       - one-cycle configuration write strobe
//   cfg_data      - committed configuration word
//   err_timeout   - one-cycle pulse, partial frame discarded
//   frame_count   - committed frames, wraps at 256
//   busy          - FSM not idle
//   err_checksum  - (CFG_CHECKSUM_EN only) one-cycle pulse, bad checksum
// Optional build macro: CFG_CHECKSUM_EN adds a 5th XOR checksum byte.
// ---------------------------------------------------------------------------
module cfg_frame_loader
    import cfg_frame_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        data_active,
    output logic        hold_data,
    output logic        cfg_wen,
    output logic [31:0] cfg_data,
    output logic        err_timeout,
    output logic [7:0]  frame_count,
    output logic        busy
`ifdef CFG_CHECKSUM_EN
    ,
    output logic        err_checksum
`endif
);

    localparam logic [7:0] DRAIN_TERM   = 8'(DRAIN_CYCLES);
    // Timeout fires on the edge that would complete TIMEOUT_CYCLES idle
    // cycles, so compare against one less than the limit.
    localparam logic [7:0] TIMEOUT_TERM = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] LAST_IDX     = 3'(CFG_FRAME_BYTES - 1);

    cfg_state_t  state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] cfg_data_q, cfg_data_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        err_timeout_q, err_timeout_d;
`ifdef CFG_CHECKSUM_EN
    logic        err_checksum_q, err_checksum_d;
`endif

    logic       accept;
    logic       to_inc, to_clr, to_at_term;
    logic       dr_inc, dr_clr, dr_at_term;
    logic [7:0] to_count, dr_count;

    // Ready is gated by rst so the host sees it low while reset is held.
    assign byte_ready = !rst && (state_q == ST_IDLE || state_q == ST_COLLECT);
    assign accept     = byte_valid && byte_ready;

    assign to_inc = (state_q == ST_COLLECT) && !accept;
    assign to_clr = (state_q != ST_COLLECT) || accept;
    assign dr_inc = (state_q == ST_DRAIN) && !data_active;
    assign dr_clr = (state_q != ST_DRAIN) || data_active;

    cfg_idle_counter u_timeout_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (to_inc),
        .clr     (to_clr),
        .term    (TIMEOUT_TERM),
        .count   (to_count),
        .at_term (to_at_term)
    );

    cfg_idle_counter u_drain_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (dr_inc),
        .clr     (dr_clr),
        .term    (DRAIN_TERM),
        .count   (dr_count),
        .at_term (dr_at_term)
    );

    always_comb begin
        state_d        = state_q;
        data_d         = data_q;
        idx_d          = idx_q;
        cfg_data_d     = cfg_data_q;
        frame_count_d  = frame_count_q;
        err_timeout_d  = 1'b0;
`ifdef CFG_CHECKSUM_EN
        err_checksum_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = put_lane(32'h0, 3'd0, byte_data);
                    idx_d   = 3'd1;
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // Acceptance takes priority over an expiring timeout.
                if (accept) begin
                    data_d = put_lane(data_q, idx_q, byte_data);
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
`ifdef CFG_CHECKSUM_EN
                        if (byte_data == frame_xor(data_q)) begin
                            state_d = ST_DRAIN;
                        end else begin
                            err_checksum_d = 1'b1;
                            data_d         = 32'h0;
                            idx_d          = 3'd0;
                            state_d        = ST_IDLE;
                        end
`else
                        state_d = ST_DRAIN;
`endif
                    end
                end else if (to_at_term) begin
                    err_timeout_d = 1'b1;
                    data_d        = 32'h0;
                    idx_d         = 3'd0;
                    state_d       = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (dr_at_term) begin
                    cfg_data_d    = data_q;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                idx_d   = 3'd0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            data_q         <= 32'h0;
            idx_q          <= 3'd0;
            cfg_data_q     <= 32'h0;
            frame_count_q  <= 8'd0;
            err_timeout_q  <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            err_checksum_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            data_q         <= data_d;
            idx_q          <= idx_d;
            cfg_data_q     <= cfg_data_d;
            frame_count_q  <= frame_count_d;
            err_timeout_q  <= err_timeout_d;
`ifdef CFG_CHECKSUM_EN
            err_checksum_q <= err_checksum_d;
`endif
        end
    end

    assign hold_data   = (state_q == ST_DRAIN) || (state_q == ST_COMMIT);
    assign cfg_wen     = (state_q == ST_COMMIT);
    assign busy        = (state_q != ST_IDLE);
    assign cfg_data    = cfg_data_q;
    assign frame_count = frame_count_q;
    assign err_timeout = err_timeout_q;
`ifdef CFG_CHECKSUM_EN
    assign err_checksum = err_checksum_q;
`endif

    // Counter values are only consumed through their terminal compares.
    logic unused_counts;
    assign unused_counts = ^{to_count, dr_count};

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed, table-driven bench for cfg_frame_loader (DRAIN_CYCLES=4,
// TIMEOUT_CYCLES=255). Follows CFG_CHECKSUM_EN when that macro is defined.
module tb_cfg_frame_loader;
    import cfg_frame_pkg::*;

    localparam int DRAIN = 4;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        data_active;
    logic        hold_data;
    logic        cfg_wen;
    logic [31:0] cfg_data;
    logic        err_timeout;
    logic [7:0]  frame_count;
    logic        busy;
`ifdef CFG_CHECKSUM_EN
    logic        err_checksum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_word;
    logic [7:0]  model_count;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          pre;
        int          act;
        logic [31:0] exp_word;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    cfg_frame_loader #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .data_active (data_active),
        .hold_data   (hold_data),
        .cfg_wen     (cfg_wen),
        .cfg_data    (cfg_data),
        .err_timeout (err_timeout),
        .frame_count (frame_count),
        .busy        (busy)
`ifdef CFG_CHECKSUM_EN
        ,
        .err_checksum(err_checksum)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until the edge that accepts it.
    task automatic applyStimulus(input logic [7:0] b);
        int g;
        g = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && g < 50) begin
            tick;
            g++;
        end
        if (g >= 50) checkOutput("ready_wait", byte_ready, 1);
        tick;
        byte_valid = 1'b0;
    endtask

    task automatic sendBytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] chk);
        applyStimulus(b0);
        applyStimulus(b1);
        applyStimulus(b2);
        applyStimulus(b3);
        if (CFG_FRAME_BYTES == 5) applyStimulus(chk);
    endtask

    // Starting right after the last byte's edge, drive data_active for
    // cycles [pre, pre+act) and follow the frame through to cfg_wen.
    task automatic waitCommit(input int pre, input int act, input int exp_lat,
                              input logic [31:0] exp_word);
        int lat;
        int hold_bad;
        int ready_bad;
        logic found;
        lat = 0; hold_bad = 0; ready_bad = 0; found = 1'b0;
        checkOutput("cfg_data_before_commit", cfg_data, model_word);
        while (!found && lat < 600) begin
            data_active = (lat >= pre && lat < pre + act);
            tick;
            lat++;
            if (!hold_data) hold_bad++;
            if (byte_ready) ready_bad++;
            if (cfg_wen) found = 1'b1;
        end
        data_active = 1'b0;
        checkOutput("commit_latency", lat, exp_lat);
        checkOutput("hold_during_drain_bad", hold_bad, 0);
        checkOutput("ready_during_drain_bad", ready_bad, 0);
        model_word  = exp_word;
        model_count = model_count + 8'd1;
        checkOutput("cfg_data", cfg_data, model_word);
        checkOutput("frame_count", frame_count, model_count);
        tick;
        checkOutput("wen_single_cycle", cfg_wen, 0);
        checkOutput("hold_drop_after_commit", hold_data, 0);
        checkOutput("busy_after_commit", busy, 0);
        checkOutput("ready_after_commit", byte_ready, 1);
        checkOutput("cfg_data_hold", cfg_data, model_word);
    endtask

    function automatic logic [31:0] frameWord(input int i);
        logic [7:0] v;
        v = 8'(i);
        return {v, v ^ 8'h55, ~v, v + 8'd1};
    endfunction

    function automatic logic [7:0] frameByte(input logic [31:0] w, input int idx);
        case (idx)
            0: return w[31:24];
            1: return w[23:16];
            2: return w[15:8];
            3: return w[7:0];
            default: return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        endcase
    endfunction

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 8'hB5, 0, 0, 32'hA53C0FB5, 5};
        vecs[1] = '{8'hA5, 8'h3C, 8'h0F, 8'hB5, 1, 3, 32'hA53C0FB5, 9};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 32'h00000000, 5};
        vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 2, 1, 32'hFFFFFFFF, 8};
        vecs[4] = '{8'h12, 8'h34, 8'h56, 8'h78, 0, 5, 32'h12345678, 10};

        model_word  = 32'h0;
        model_count = 8'd0;
        rst         = 1'b1;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        data_active = 1'b0;

        // Reset state, sampled while reset is held.
        tick;
        tick;
        checkOutput("reset_byte_ready", byte_ready, 0);
        checkOutput("reset_hold_data", hold_data, 0);
        checkOutput("reset_cfg_wen", cfg_wen, 0);
        checkOutput("reset_cfg_data", cfg_data, 32'h0);
        checkOutput("reset_err_timeout", err_timeout, 0);
        checkOutput("reset_frame_count", frame_count, 0);
        checkOutput("reset_busy", busy, 0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", byte_ready, 1);
        tick;

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            sendBytes(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3,
                      vecs[i].b0 ^ vecs[i].b1 ^ vecs[i].b2 ^ vecs[i].b3);
            waitCommit(vecs[i].pre, vecs[i].act, vecs[i].exp_lat, vecs[i].exp_word);
            tick;
        end

        // Partial frame abandoned for TMO idle cycles.
        begin
            int n;
            int wen_seen;
            logic seen;
            n = 0; wen_seen = 0; seen = 1'b0;
            applyStimulus(8'hDE);
            applyStimulus(8'hAD);
            checkOutput("busy_in_collect", busy, 1);
            while (!seen && n < 300) begin
                tick;
                n++;
                if (cfg_wen) wen_seen++;
                if (err_timeout) seen = 1'b1;
            end
            checkOutput("timeout_cycles", n, TMO);
            checkOutput("timeout_no_wen", wen_seen, 0);
            checkOutput("timeout_busy", busy, 0);
            checkOutput("timeout_cfg_data", cfg_data, model_word);
            checkOutput("timeout_frame_count", frame_count, model_count);
            tick;
            checkOutput("timeout_pulse_width", err_timeout, 0);
            sendBytes(8'hA5, 8'h3C, 8'h0F, 8'hB5, 8'hA5 ^ 8'h3C ^ 8'h0F ^ 8'hB5);
            waitCommit(0, 0, 5, 32'hA53C0FB5);
            tick;
        end

        // A byte arriving on the very edge the timeout would expire wins.
        begin
            int errs;
            errs = 0;
            applyStimulus(8'h01);
            for (int i = 0; i < TMO - 1; i++) begin
                tick;
                if (err_timeout) errs++;
            end
            applyStimulus(8'h02);
            if (err_timeout) errs++;
            checkOutput("accept_beats_timeout_err", errs, 0);
            checkOutput("accept_beats_timeout_busy", busy, 1);
            applyStimulus(8'h03);
            applyStimulus(8'h04);
            if (CFG_FRAME_BYTES == 5) applyStimulus(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
            waitCommit(0, 0, 5, 32'h01020304);
            tick;
        end

        // Reset in the middle of a frame.
        begin
            int wen_seen;
            wen_seen = 0;
            applyStimulus(8'h77);
            applyStimulus(8'h88);
            #2;
            rst = 1'b1;
            #1;
            checkOutput("midrst_byte_ready", byte_ready, 0);
            checkOutput("midrst_hold_data", hold_data, 0);
            checkOutput("midrst_cfg_wen", cfg_wen, 0);
            checkOutput("midrst_cfg_data", cfg_data, 32'h0);
            checkOutput("midrst_frame_count", frame_count, 0);
            checkOutput("midrst_busy", busy, 0);
            tick;
            rst = 1'b0;
            model_word  = 32'h0;
            model_count = 8'd0;
            #1;
            checkOutput("midrst_ready_after", byte_ready, 1);
            for (int i = 0; i < 10; i++) begin
                tick;
                if (cfg_wen) wen_seen++;
            end
            checkOutput("midrst_no_wen", wen_seen, 0);
            checkOutput("midrst_idle", busy, 0);
        end

        // 256 back-to-back frames with byte_valid held high.
        begin
            int fidx, bidx, wens, cyc, ready_bad, double_wen;
            logic r, prev_wen;
            fidx = 0; bidx = 0; wens = 0; cyc = 0; ready_bad = 0; double_wen = 0;
            prev_wen = 1'b0;
            byte_valid = 1'b1;
            byte_data  = frameByte(frameWord(0), 0);
            while (wens < 256 && cyc < 5000) begin
                r = byte_ready;
                tick;
                cyc++;
                if (r) begin
                    bidx++;
                    if (bidx == CFG_FRAME_BYTES) begin
                        bidx = 0;
                        fidx++;
                    end
                    byte_data = frameByte(frameWord(fidx), bidx);
                end
                if (hold_data && byte_ready) ready_bad++;
                if (prev_wen && cfg_wen) double_wen++;
                prev_wen = cfg_wen;
                if (cfg_wen) wens++;
            end
            byte_valid = 1'b0;
            checkOutput("b2b_wen_pulses", wens, 256);
            checkOutput("b2b_ready_in_hold", ready_bad, 0);
            checkOutput("b2b_wen_width", double_wen, 0);
            checkOutput("b2b_frame_count_wrap", frame_count, model_count);
            checkOutput("b2b_last_word", cfg_data, frameWord(255));
            model_word = frameWord(255);
            tick;
            tick;
        end

`ifdef CFG_CHECKSUM_EN
        // Checksum: good frame commits, corrupted checksum is rejected.
        begin
            int wen_seen;
            wen_seen = 0;
            sendBytes(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
            waitCommit(0, 0, 5, 32'h11223344);
            tick;
            sendBytes(8'h11, 8'h22, 8'h33, 8'h44, 8'h45);
            checkOutput("chk_err_pulse", err_checksum, 1);
            checkOutput("chk_err_idle", busy, 0);
            tick;
            checkOutput("chk_err_width", err_checksum, 0);
            for (int i = 0; i < 10; i++) begin
                tick;
                if (cfg_wen) wen_seen++;
            end
            checkOutput("chk_no_wen", wen_seen, 0);
            checkOutput("chk_cfg_data", cfg_data, model_word);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
